alu_issue_stage: RTL and testbench

- Operand-issue stage directly upstream of the 64-bit ripple ALU.
- Accepts decoded instructions from decode/register-read and selects operand B (register or immediate).
- Applies writeback forwarding to incoming and held operands.
- Buffers up to two instructions in a skid buffer and presents a, b, ALUOp and CarryIn to the ALU under a valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the 64-bit ALU: operand B select,
// writeback forwarding and a two-entry skid buffer.
module alu_issue_stage #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [DATA_W-1:0]     in_rs2_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [DATA_W-1:0]     fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [3:0]            out_aluop,
    output logic                  out_carryin,
    output logic [REG_ADDR_W-1:0] out_rd_addr
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [3:0] OP_SUB  = 4'b0110;

    typedef struct packed {
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
        logic [3:0]            op;
        logic                  cin;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_imm;
    } ent_t;

    logic [1:0] r_state;
    ent_t       r_head;
    ent_t       r_skid;

    logic [1:0] w_state_nx;
    ent_t       w_head_nx;
    ent_t       w_skid_nx;
    ent_t       w_new;
    ent_t       w_head_f;
    ent_t       w_skid_f;
    logic       w_push;
    logic       w_pop;
    logic       w_fwd_en;

    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_fwd_en  = fwd_valid && (fwd_rd != '0);

    assign out_a       = r_head.a;
    assign out_b       = r_head.b;
    assign out_aluop   = r_head.op;
    assign out_carryin = r_head.cin;
    assign out_rd_addr = r_head.rd;

    // Incoming instruction, with capture-time forwarding
    always_comb begin
        w_new.op      = in_op;
        w_new.cin     = (in_op == OP_SUB);
        w_new.rd      = in_rd_addr;
        w_new.rs1     = in_rs1_addr;
        w_new.rs2     = in_rs2_addr;
        w_new.use_imm = in_use_imm;
        w_new.a       = in_rs1_data;
        w_new.b       = in_use_imm ? in_imm : in_rs2_data;
        if (w_fwd_en && fwd_rd == in_rs1_addr)
            w_new.a = fwd_data;
        if (w_fwd_en && !in_use_imm && fwd_rd == in_rs2_addr)
            w_new.b = fwd_data;
    end

    // Held entries track writeback so stalled operands stay current
    always_comb begin
        w_head_f = r_head;
        w_skid_f = r_skid;
        if (w_fwd_en && fwd_rd == r_head.rs1)
            w_head_f.a = fwd_data;
        if (w_fwd_en && !r_head.use_imm && fwd_rd == r_head.rs2)
            w_head_f.b = fwd_data;
        if (w_fwd_en && fwd_rd == r_skid.rs1)
            w_skid_f.a = fwd_data;
        if (w_fwd_en && !r_skid.use_imm && fwd_rd == r_skid.rs2)
            w_skid_f.b = fwd_data;
    end

    always_comb begin
        w_state_nx = r_state;
        w_head_nx  = r_head;
        w_skid_nx  = r_skid;
        if (flush) begin
            w_state_nx = S_EMPTY;
            w_head_nx  = '0;
            w_skid_nx  = '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nx = S_ONE;
                        w_head_nx  = w_new;
                    end
                end
                S_ONE: begin
                    w_head_nx = w_head_f;
                    if (w_push && w_pop) begin
                        w_head_nx = w_new;
                    end else if (w_push) begin
                        w_state_nx = S_FULL;
                        w_skid_nx  = w_new;
                    end else if (w_pop) begin
                        w_state_nx = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_nx = S_ONE;
                        w_head_nx  = w_skid_f;
                        w_skid_nx  = '0;
                    end else begin
                        w_head_nx = w_head_f;
                        w_skid_nx = w_skid_f;
                    end
                end
                default: begin
                    w_state_nx = S_EMPTY;
                    w_head_nx  = '0;
                    w_skid_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_head  <= w_head_nx;
            r_skid  <= w_skid_nx;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd_addr;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic [3:0]  out_aluop;
    logic        out_carryin;
    logic [4:0]  out_rd_addr;

    int n_cmp;
    int n_bad;

    alu_issue_stage #(.DATA_W(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_aluop(out_aluop),
        .out_carryin(out_carryin), .out_rd_addr(out_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] imm,
                         input logic ui, input logic [4:0] rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1_addr = a1;
        in_rs2_addr = a2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_use_imm  = ui;
        in_rd_addr  = rd;
    endtask

    task automatic fill_full();
        out_ready = 1'b0;
        drive(4'd0, 5'd1, 5'd2, 64'hA1, 64'hB1, 64'h0, 1'b0, 5'd1);
        tick();
        drive(4'd6, 5'd1, 5'd2, 64'hA2, 64'hB2, 64'h0, 1'b0, 5'd2);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_rs1_addr = '0;
        in_rs2_addr = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        in_imm = '0;
        in_use_imm = 1'b0;
        in_rd_addr = '0;
        fwd_valid = 1'b0;
        fwd_rd = '0;
        fwd_data = '0;
        out_ready = 1'b0;

        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_a", out_a, 64'd0);
        reset_n = 1'b1;
        tick();

        // basic push, latency one cycle
        out_ready = 1'b1;
        drive(4'b0010, 5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 1'b0, 5'd3);
        chk("lat_pre_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_a", out_a, 64'd5);
        chk("t1_b", out_b, 64'd7);
        chk("t1_op", 64'(out_aluop), 64'd2);
        chk("t1_cin", 64'(out_carryin), 64'd0);
        chk("t1_rd", 64'(out_rd_addr), 64'd3);

        // subtract with immediate, push+pop replaces head
        drive(4'b0110, 5'd1, 5'd2, 64'd1, 64'd9,
              64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 5'd4);
        tick();
        in_valid = 1'b0;
        chk("t2_b", out_b, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t2_cin", 64'(out_carryin), 64'd1);
        chk("t2_op", 64'(out_aluop), 64'd6);
        tick();
        chk("t2_drain", 64'(out_valid), 64'd0);

        // back-pressure: fill, ignored third, drain in order
        out_ready = 1'b0;
        drive(4'd0, 5'd1, 5'd2, 64'd11, 64'd0, 64'd0, 1'b0, 5'd5);
        tick();
        drive(4'd0, 5'd1, 5'd2, 64'd22, 64'd0, 64'd0, 1'b0, 5'd6);
        tick();
        chk("t3_full_rdy", 64'(in_ready), 64'd0);
        drive(4'd0, 5'd1, 5'd2, 64'd33, 64'd0, 64'd0, 1'b0, 5'd7);
        tick();
        in_valid = 1'b0;
        chk("t3_hold_a", out_a, 64'd11);
        chk("t3_hold_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("t3_pop1_a", out_a, 64'd22);
        chk("t3_pop1_rd", 64'(out_rd_addr), 64'd6);
        chk("t3_pop1_rdy", 64'(in_ready), 64'd1);
        tick();
        chk("t3_empty", 64'(out_valid), 64'd0);

        // held-head forwarding
        out_ready = 1'b0;
        drive(4'd0, 5'd4, 5'd2, 64'd100, 64'd0, 64'd0, 1'b0, 5'd8);
        tick();
        in_valid = 1'b0;
        fwd_valid = 1'b1;
        fwd_rd = 5'd4;
        fwd_data = 64'hDEAD;
        chk("t4_pre_a", out_a, 64'd100);
        tick();
        fwd_valid = 1'b0;
        chk("t4_fwd_a", out_a, 64'hDEAD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // register 0 never forwarded
        drive(4'd0, 5'd0, 5'd2, 64'd200, 64'd0, 64'd0, 1'b0, 5'd8);
        tick();
        in_valid = 1'b0;
        fwd_valid = 1'b1;
        fwd_rd = 5'd0;
        fwd_data = 64'hBEEF;
        tick();
        fwd_valid = 1'b0;
        chk("t4_r0_a", out_a, 64'd200);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // capture-time forwarding; immediate B never forwarded
        drive(4'd0, 5'd9, 5'd9, 64'd1, 64'd2, 64'h44, 1'b1, 5'd8);
        fwd_valid = 1'b1;
        fwd_rd = 5'd9;
        fwd_data = 64'h77;
        tick();
        in_valid = 1'b0;
        fwd_valid = 1'b0;
        chk("t4_cap_a", out_a, 64'h77);
        chk("t4_cap_b_imm", out_b, 64'h44);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // skid entry forwarded while stalled, carried on promotion
        drive(4'd0, 5'd10, 5'd2, 64'd1, 64'd0, 64'd0, 1'b0, 5'd1);
        tick();
        drive(4'd0, 5'd11, 5'd12, 64'd2, 64'd3, 64'd0, 1'b0, 5'd2);
        tick();
        in_valid = 1'b0;
        fwd_valid = 1'b1;
        fwd_rd = 5'd12;
        fwd_data = 64'h55;
        tick();
        fwd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_skid_b", out_b, 64'h55);
        chk("t4_skid_a", out_a, 64'd2);
        tick();
        chk("t4_skid_empty", 64'(out_valid), 64'd0);

        // flush beats push while FULL
        fill_full();
        drive(4'd0, 5'd1, 5'd2, 64'd99, 64'd0, 64'd0, 1'b0, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t5_nocap", 64'(out_valid), 64'd0);

        // asynchronous reset while FULL
        fill_full();
        chk("t6_pre_full", 64'(in_ready), 64'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_a", out_a, 64'd0);
        chk("t6_b", out_b, 64'd0);
        chk("t6_op", 64'(out_aluop), 64'd0);
        chk("t6_cin", 64'(out_carryin), 64'd0);
        chk("t6_rd", 64'(out_rd_addr), 64'd0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
